// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life video path.
package gol_pkg;

  localparam int GRID_W = 256;
  localparam int GRID_H = 256;
  localparam int CELL_W = 5;

  // Default 640x480@60 raster timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [CELL_W-1:0] species_t;
  typedef logic [23:0]       rgb_t;

  // Per-pixel timing flags carried down the scanout pipeline
  typedef struct packed {
    logic act;
    logic win;
    logic hs;
    logic vs;
  } pix_flags_t;

endpackage

// File: rtl/gol_palette.sv
// Species code to RGB colour map; species 0 is an empty (black) cell.
module gol_palette
  import gol_pkg::*;
(
  input  logic [CELL_W-1:0] i_species,
  output logic [23:0]       o_rgb
);

  // Bit-shuffle map gives each species a distinct hue without a table
  always_comb begin
    o_rgb = '0;
    if (i_species != '0)
      o_rgb = {i_species, i_species[4:2],
               i_species[2:0], i_species,
               ~i_species, 3'b111};
  end

endmodule

// File: rtl/gol_scanout.sv
// Raster generator and display-bank reader for the 256x256 cell grid.
// Pipeline: counters -> address register -> RAM data mux -> output regs,
// so a counter position reaches the pins 3 cycles later.
module gol_scanout
  import gol_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SYNC     = DEF_H_SYNC,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SYNC     = DEF_V_SYNC,
  parameter int          V_BP       = DEF_V_BP,
  parameter logic        SYNC_NEG   = 1'b1,
  parameter int          X_OFF      = 192,
  parameter int          Y_OFF      = 112,
  parameter logic [23:0] BORDER_RGB = 24'h202020
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_select,
  input  logic              init_done,
  input  logic [CELL_W-1:0] dout_bank0,
  input  logic [CELL_W-1:0] dout_bank1,
  output logic [15:0]       rd_addr,
  output logic              video_sof,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [23:0]       rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = 12;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] XW_BEG = CW'(X_OFF);
  localparam logic [CW-1:0] XW_END = CW'(X_OFF + GRID_W);
  localparam logic [7:0]    XO8    = 8'(X_OFF);

  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_PRE  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] YW_BEG = CW'(Y_OFF);
  localparam logic [CW-1:0] YW_END = CW'(Y_OFF + GRID_H);
  localparam logic [7:0]    YO8    = 8'(Y_OFF);

  logic [CW-1:0] r_h, r_v;
  logic          r_bank_q;
  pix_flags_t    w_flg0, r_flg1, r_flg2;
  logic [7:0]    w_gx, w_gy;
  species_t      w_cell;
  rgb_t          w_pal;

  // Raster counters: h wraps each line, v advances on h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Stage 0 decode of the current counter position
  always_comb begin
    w_flg0     = '0;
    w_flg0.act = (r_h < H_ACT) && (r_v < V_ACT);
    w_flg0.win = w_flg0.act && (r_h >= XW_BEG) && (r_h < XW_END) &&
                 (r_v >= YW_BEG) && (r_v < YW_END);
    w_flg0.hs  = (r_h >= HS_BEG) && (r_h < HS_END);
    w_flg0.vs  = (r_v >= VS_BEG) && (r_v < VS_END);
  end

  // Grid coordinates only need the low byte; the window check bounds them
  assign w_gx = r_h[7:0] - XO8;
  assign w_gy = r_v[7:0] - YO8;

  // Stage 1: issue the RAM read; address holds outside the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      r_flg1  <= '0;
    end else begin
      if (w_flg0.win) rd_addr <= {w_gy, w_gx};
      r_flg1 <= w_flg0;
    end
  end

  // Stage 2 flags line up with the RAM data returning this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flg2 <= '0;
    else        r_flg2 <= r_flg1;
  end

  // Display bank is frozen for a whole frame so a mid-frame swap cannot tear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_bank_q <= 1'b0;
    else if (r_h == '0 && r_v == '0)    r_bank_q <= ram_select;
  end

  assign w_cell = r_bank_q ? dout_bank1 : dout_bank0;

  gol_palette u_pal (
    .i_species (w_cell),
    .o_rgb     (w_pal)
  );

  // Stage 3: registered pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      hsync <= SYNC_NEG;
      vsync <= SYNC_NEG;
      rgb   <= '0;
    end else begin
      de    <= r_flg2.act;
      hsync <= r_flg2.hs ^ SYNC_NEG;
      vsync <= r_flg2.vs ^ SYNC_NEG;
      if (!r_flg2.act)      rgb <= '0;
      else if (!r_flg2.win) rgb <= BORDER_RGB;
      else if (!init_done)  rgb <= '0;
      else                  rgb <= w_pal;
    end
  end

  // Frame-start pulse, decoded one cycle early so it is high while the
  // counters sit at the first vertical front porch position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) video_sof <= 1'b0;
    else        video_sof <= (r_h == H_LAST) && (r_v == V_PRE);
  end

endmodule

// File: tb/tb_gol_scanout.sv
// Directed bench for gol_scanout using a shrunken raster so several
// frames fit in a short run. Bank0 returns rd_addr[4:0], bank1 returns 31.
module tb_gol_scanout;

  localparam int HA = 264, HF = 4, HS = 8, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 2;
  localparam int XO = 4, YO = 2;
  localparam int HT = HA + HF + HS + HB;   // 280
  localparam int VT = VA + VF + VS + VB;   // 14
  localparam int FRAME = HT * VT;          // 3920

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_select = 1'b0;
  logic        init_done = 1'b1;
  logic [4:0]  dout_bank0 = '0;
  logic [4:0]  dout_bank1 = '0;
  logic [15:0] rd_addr;
  logic        video_sof, hsync, vsync, de;
  logic [23:0] rgb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  gol_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_NEG(1'b1), .X_OFF(XO), .Y_OFF(YO), .BORDER_RGB(24'h202020)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ram_select(ram_select), .init_done(init_done),
    .dout_bank0(dout_bank0), .dout_bank1(dout_bank1), .rd_addr(rd_addr),
    .video_sof(video_sof), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM models
  always @(posedge clk) begin
    dout_bank0 <= rd_addr[4:0];
    dout_bank1 <= 5'd31;
  end

  typedef struct {
    int          h;
    int          v;
    logic [15:0] addr;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance to the negedge of cycle t (cycle 0 = first cycle after reset release)
  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic new_frame();
    base = (cyc / FRAME + 1) * FRAME;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_de"}, de, 1'b0);
    chk({tag, "_rgb"}, rgb, 24'h0);
    chk({tag, "_rd_addr"}, rd_addr, 16'h0);
    chk({tag, "_sof"}, video_sof, 1'b0);
  endtask

  initial begin
    int p;
    int nsof, first_sof, second_sof;

    //        h    v    addr      rgb          de hs vs
    tbl[0]  = '{0,   0,  16'h0000, 24'h202020, 1, 1, 1};
    tbl[1]  = '{5,   1,  16'h0000, 24'h202020, 1, 1, 1};
    tbl[2]  = '{4,   2,  16'h0000, 24'h000000, 1, 1, 1};
    tbl[3]  = '{7,   2,  16'h0003, 24'h1863E7, 1, 1, 1};
    tbl[4]  = '{22,  2,  16'h0012, 24'h94526F, 1, 1, 1};
    tbl[5]  = '{35,  2,  16'h001F, 24'hFFFF07, 1, 1, 1};
    tbl[6]  = '{259, 2,  16'h00FF, 24'hFFFF07, 1, 1, 1};
    tbl[7]  = '{262, 2,  16'h00FF, 24'h202020, 1, 1, 1};
    tbl[8]  = '{264, 2,  16'h00FF, 24'h000000, 0, 1, 1};
    tbl[9]  = '{268, 2,  16'h00FF, 24'h000000, 0, 0, 1};
    tbl[10] = '{272, 2,  16'h00FF, 24'h000000, 0, 0, 1};
    tbl[11] = '{276, 2,  16'h00FF, 24'h000000, 0, 1, 1};
    tbl[12] = '{3,   3,  16'h00FF, 24'h202020, 1, 1, 1};
    tbl[13] = '{5,   4,  16'h0201, 24'h0821F7, 1, 1, 1};
    tbl[14] = '{6,   5,  16'h0302, 24'h1042EF, 1, 1, 1};
    tbl[15] = '{0,   8,  16'h05FF, 24'h000000, 0, 1, 1};
    tbl[16] = '{0,   10, 16'h05FF, 24'h000000, 0, 1, 0};
    tbl[17] = '{100, 11, 16'h05FF, 24'h000000, 0, 1, 0};
    tbl[18] = '{0,   12, 16'h05FF, 24'h000000, 0, 1, 1};
    tbl[19] = '{279, 13, 16'h05FF, 24'h000000, 0, 1, 1};

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = -1;
    base = 0;
    goto(0);

    // Vector table over the raster, bank0 displayed
    for (int i = 0; i < 20; i++) begin
      p = base + tbl[i].v * HT + tbl[i].h;
      if (p + 1 < cyc) begin
        base += FRAME;
        p += FRAME;
      end
      goto(p + 1);
      chk($sformatf("tbl%0d_addr", i), rd_addr, tbl[i].addr);
      goto(p + 3);
      chk($sformatf("tbl%0d_rgb", i), rgb, tbl[i].rgb);
      chk($sformatf("tbl%0d_de", i), de, tbl[i].de);
      chk($sformatf("tbl%0d_hsync", i), hsync, tbl[i].hs);
      chk($sformatf("tbl%0d_vsync", i), vsync, tbl[i].vs);
    end

    // Bank swap mid-frame only takes effect at the next frame
    new_frame();
    ram_select = 1'b0;
    goto(base + 4 * HT);
    ram_select = 1'b1;
    goto(base + 6 * HT + 5 + 3);
    chk("swap_same_frame_col1", rgb, 24'h0821F7);
    goto(base + 7 * HT + 6 + 3);
    chk("swap_same_frame_col2", rgb, 24'h1042EF);
    base += FRAME;
    goto(base + 3 * HT + 6 + 3);
    chk("swap_next_frame", rgb, 24'hFFFF07);

    // Seeding blanks the window but not the border
    init_done = 1'b0;
    new_frame();
    goto(base + 3 * HT + 1 + 3);
    chk("seed_border", rgb, 24'h202020);
    goto(base + 3 * HT + 5 + 3);
    chk("seed_window", rgb, 24'h000000);
    goto(base + 3 * HT + 9 + 3);
    chk("seed_last_black", rgb, 24'h000000);
    init_done = 1'b1;
    goto(base + 3 * HT + 10 + 3);
    chk("seed_done_next_px", rgb, 24'hFFFF07);

    // Asynchronous reset in the middle of active video
    new_frame();
    goto(base + 5 * HT + 100);
    chk("pre_rst_de", de, 1'b1);
    chk("pre_rst_rgb", rgb, 24'hFFFF07);
    chk("pre_rst_addr", rd_addr, 16'h035F);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = -1;
    base = 0;

    // Restart timing and two frames of video_sof
    nsof = 0;
    first_sof = -1;
    second_sof = -1;
    for (int c = 0; c <= 2 * FRAME + 4; c++) begin
      goto(c);
      if (c == 2) chk("rst_de_low_c2", de, 1'b0);
      if (c == 3) chk("rst_de_rise_c3", de, 1'b1);
      if (video_sof) begin
        if (nsof == 0) first_sof = c;
        else if (nsof == 1) second_sof = c;
        nsof++;
      end
    end
    chk("sof_count", nsof, 2);
    chk("sof_first_pos", first_sof, VA * HT);
    chk("sof_period", second_sof - first_sof, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
